i281_run_ctrl: RTL and testbench

I281_RUN_CTRL -- requirements
Module: i281_run_ctrl

---
 rtl/i281_run_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i281_run_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i281_run_ctrl.sv
// Run/step/halt sequencer for the i281 CPU core with a cycle budget and data-memory view.
// Define I281_SNAPSHOT_EN to freeze the data memory on the edge entering HALT or TIMEOUT.
module i281_run_ctrl #(
    parameter int DATA_W       = 8,
    parameter int MEM_DEPTH    = 16,
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          run_req,
    input  logic                          step_req,
    input  logic                          halt_req,
    input  logic                          clear_req,
    input  logic [CNT_W-1:0]              cycle_limit,
    input  logic [MEM_DEPTH*DATA_W-1:0]   datamem,
    input  logic [$clog2(MEM_DEPTH)-1:0]  sel,
    output logic                          cpu_reset,
    output logic                          cpu_run,
    output logic [2:0]                    state,
    output logic [CNT_W-1:0]              cycle_count,
    output logic                          done,
    output logic [DATA_W-1:0]             snap_data
);

    // state    | meaning
    // ---------+----------------------------------------------------
    // RST_HOLD | CPU held in reset for RESET_CYCLES cycles
    // IDLE     | CPU out of reset, clock enable off, awaiting request
    // RUN      | free-running, clock enable on every cycle
    // STEP     | single clock-enable cycle, then back to IDLE
    // HALT     | stopped on request, resumable with run_req
    // TIMEOUT  | cycle budget used up, left only via clear_req
    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RUN      = 3'd2,
        ST_STEP     = 3'd3,
        ST_HALT     = 3'd4,
        ST_TIMEOUT  = 3'd5
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(RESET_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        hold_q, hold_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              step_arm_q, step_arm_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              cpu_run_q, cpu_run_d;
    logic              done_q, done_d;
    logic              clear_hit;
    logic              limit_hit;

    logic [DATA_W-1:0] mem_word [MEM_DEPTH];

    for (genvar i = 0; i < MEM_DEPTH; i++) begin : g_word
        assign mem_word[i] = datamem[i*DATA_W +: DATA_W];
    end

    assign clear_hit = clear_req && (state_q != ST_RST_HOLD);

    // Widened by one bit so a saturated counter never aliases onto a small limit.
    assign limit_hit = (cycle_limit != '0) &&
                       (({1'b0, cycle_count_q} + (CNT_W+1)'(1)) == {1'b0, cycle_limit});

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        cycle_count_d = cycle_count_q;
        step_arm_d    = step_arm_q | ~step_req;

        if (cpu_run_q && (cycle_count_q != '1)) begin
            cycle_count_d = cycle_count_q + CNT_W'(1);
        end

        if (clear_hit) begin
            state_d       = ST_RST_HOLD;
            hold_d        = '0;
            cycle_count_d = '0;
        end else begin
            case (state_q)
                ST_RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
                ST_IDLE: begin
                    if (run_req) begin
                        state_d = ST_RUN;
                    end else if (step_req && step_arm_q) begin
                        state_d    = ST_STEP;
                        step_arm_d = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_d = ST_HALT;
                    end else if (limit_hit) begin
                        state_d = ST_TIMEOUT;
                    end
                end
                ST_STEP: begin
                    state_d = ST_IDLE;
                end
                ST_HALT: begin
                    if (run_req && !halt_req) begin
                        state_d = ST_RUN;
                    end
                end
                ST_TIMEOUT: begin
                    state_d = ST_TIMEOUT;
                end
                default: begin
                    state_d = ST_RST_HOLD;
                    hold_d  = '0;
                end
            endcase
        end

        // Outputs decoded from the next state so the flops line up with state_q.
        cpu_reset_d = (state_d == ST_RST_HOLD);
        cpu_run_d   = (state_d == ST_RUN) || (state_d == ST_STEP);
        done_d      = (state_d == ST_HALT) || (state_d == ST_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RST_HOLD;
            hold_q        <= '0;
            cycle_count_q <= '0;
            step_arm_q    <= 1'b1;
            cpu_reset_q   <= 1'b1;
            cpu_run_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            cycle_count_q <= cycle_count_d;
            step_arm_q    <= step_arm_d;
            cpu_reset_q   <= cpu_reset_d;
            cpu_run_q     <= cpu_run_d;
            done_q        <= done_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign cpu_run     = cpu_run_q;
    assign done        = done_q;
    assign state       = state_q;
    assign cycle_count = cycle_count_q;

`ifdef I281_SNAPSHOT_EN
    logic [DATA_W-1:0] snap_q [MEM_DEPTH];
    logic [DATA_W-1:0] snap_d [MEM_DEPTH];

    always_comb begin
        snap_d = snap_q;
        if (clear_req) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                snap_d[i] = '0;
            end
        end else if (done_d && !done_q) begin
            snap_d = mem_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            snap_q <= snap_d;
        end
    end

    assign snap_data = snap_q[sel];
`else
    assign snap_data = mem_word[sel];
`endif

endmodule

// File: tb/tb_i281_run_ctrl.sv
// Directed self-checking bench for i281_run_ctrl (default parameters).
module tb_i281_run_ctrl;

    logic          clock = 1'b0;
    logic          reset;
    logic          run_req;
    logic          step_req;
    logic          halt_req;
    logic          clear_req;
    logic [15:0]   cycle_limit;
    logic [127:0]  datamem;
    logic [3:0]    sel;
    logic          cpu_reset;
    logic          cpu_run;
    logic [2:0]    state;
    logic [15:0]   cycle_count;
    logic          done;
    logic [7:0]    snap_data;

    int n_checks = 0;
    int n_pass   = 0;
    int run_cycles;
    logic seen;

    i281_run_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .run_req     (run_req),
        .step_req    (step_req),
        .halt_req    (halt_req),
        .clear_req   (clear_req),
        .cycle_limit (cycle_limit),
        .datamem     (datamem),
        .sel         (sel),
        .cpu_reset   (cpu_reset),
        .cpu_run     (cpu_run),
        .state       (state),
        .cycle_count (cycle_count),
        .done        (done),
        .snap_data   (snap_data)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; clear_req = 1'b0;
        cycle_limit = '0; datamem = '0; sel = '0;

        tick(); tick();
        chk("rst_state", state, 3'd0);
        chk("rst_cpu_reset", cpu_reset, 1'b1);
        chk("rst_cpu_run", cpu_run, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_count", cycle_count, 16'd0);

        reset = 1'b0;
        tick();
        chk("hold1_state", state, 3'd0);
        chk("hold1_cpu_reset", cpu_reset, 1'b1);
        tick();
        chk("hold2_state", state, 3'd1);
        chk("hold2_cpu_reset", cpu_reset, 1'b0);
        chk("hold2_cpu_run", cpu_run, 1'b0);
        chk("hold2_count", cycle_count, 16'd0);

        // Budgeted run to timeout
        cycle_limit = 16'd10;
        run_req = 1'b1;
        run_cycles = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cpu_run) run_cycles++;
            if (done) break;
        end
        chk("lim_run_cycles", run_cycles, 10);
        chk("lim_state", state, 3'd5);
        chk("lim_done", done, 1'b1);
        chk("lim_count", cycle_count, 16'd10);
        run_req = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        chk("timeout_sticky", state, 3'd5);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clr_state", state, 3'd0);
        chk("clr_count", cycle_count, 16'd0);
        chk("clr_cpu_reset", cpu_reset, 1'b1);
        chk("clr_done", done, 1'b0);
        tick(); tick();
        chk("clr_idle", state, 3'd1);

        // Held step gives exactly one enabled cycle
        cycle_limit = '0;
        step_req = 1'b1;
        run_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (cpu_run) run_cycles++;
        end
        step_req = 1'b0;
        tick();
        chk("step_run_cycles", run_cycles, 1);
        chk("step_count", cycle_count, 16'd1);
        chk("step_state", state, 3'd1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("step2_state", state, 3'd3);
        chk("step2_cpu_run", cpu_run, 1'b1);
        tick();
        chk("step2_idle", state, 3'd1);
        chk("step2_count", cycle_count, 16'd2);

        // Halt at count 7, snapshot, resume
        do_clear();
        chk("pre_halt_idle", state, 3'd1);
        run_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (cycle_count == 16'd6) begin
                seen = 1'b1;
                break;
            end
        end
        chk("wait_count6", seen, 1'b1);
        datamem[3*8 +: 8] = 8'h5A;
        sel = 4'd3;
        halt_req = 1'b1;
        tick();
        chk("halt_state", state, 3'd4);
        chk("halt_count", cycle_count, 16'd7);
        chk("halt_done", done, 1'b1);
        chk("halt_cpu_run", cpu_run, 1'b0);
        tick();
        chk("halt_hold_state", state, 3'd4);
        chk("halt_hold_count", cycle_count, 16'd7);
        datamem[3*8 +: 8] = 8'h11;
        #1;
`ifdef I281_SNAPSHOT_EN
        chk("snap_data", snap_data, 8'h5A);
`else
        chk("snap_data", snap_data, 8'h11);
`endif
        halt_req = 1'b0;
        tick();
        chk("resume_state", state, 3'd2);
        chk("resume_count", cycle_count, 16'd7);
        chk("resume_cpu_run", cpu_run, 1'b1);
        tick();
        chk("resume_count8", cycle_count, 16'd8);

        // Limit below count never fires; a later exact match does
        cycle_limit = 16'd5;
        tick(); tick(); tick();
        chk("low_limit_state", state, 3'd2);
        chk("low_limit_count", cycle_count, 16'd11);
        cycle_limit = 16'd14;
        tick(); tick();
        chk("new_limit_pre", state, 3'd2);
        tick();
        chk("new_limit_state", state, 3'd5);
        chk("new_limit_count", cycle_count, 16'd14);
        run_req = 1'b0;

        // Clear beats halt in RUN
        cycle_limit = '0;
        do_clear();
        run_req = 1'b1;
        tick(); tick(); tick();
        clear_req = 1'b1;
        halt_req = 1'b1;
        tick();
        clear_req = 1'b0;
        halt_req = 1'b0;
        run_req = 1'b0;
        chk("clrhalt_state", state, 3'd0);
        chk("clrhalt_count", cycle_count, 16'd0);
        chk("clrhalt_cpu_reset", cpu_reset, 1'b1);
        chk("clrhalt_cpu_run", cpu_run, 1'b0);
        tick();
        chk("clrhalt_hold", state, 3'd0);
        tick();
        chk("clrhalt_idle", state, 3'd1);

        // Run outranks step in IDLE; reset mid-RUN drops cpu_run
        run_req = 1'b1;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        chk("run_prio_state", state, 3'd2);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_cpu_run", cpu_run, 1'b0);
        chk("midrst_state", state, 3'd0);
        chk("midrst_count", cycle_count, 16'd0);
        reset = 1'b0;
        run_req = 1'b0;
        tick();
        chk("midrst_hold", cpu_reset, 1'b1);
        tick();
        chk("midrst_idle", state, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
